// File: rtl/jtag_tap_param_if.sv
// TAP serial pins, debug taps and pad/core signals of the boundary-scan TAP.
// The slave modport is the TAP itself; master is whatever drives the pins.
interface jtag_tap_param_if #(
    parameter int IR_W  = 4,
    parameter int PIN_N = 4
);
    logic             TMS;
    logic             TDI;
    logic             TDO;
    logic             TDO_EN;
    logic [3:0]       tap_state;
    logic [IR_W-1:0]  ir_out;
    logic [PIN_N-1:0] pin_in;
    logic [PIN_N-1:0] core_in;
    logic [PIN_N-1:0] core_out;
    logic [PIN_N-1:0] pin_out;
    logic [PIN_N-1:0] pin_oe;
    logic [PIN_N-1:0] core_oe;

    modport slave (
        input  TMS, TDI, pin_in, core_out, core_oe,
        output TDO, TDO_EN, tap_state, ir_out, core_in, pin_out, pin_oe
    );

    modport master (
        output TMS, TDI, pin_in, core_out, core_oe,
        input  TDO, TDO_EN, tap_state, ir_out, core_in, pin_out, pin_oe
    );
endinterface

// File: rtl/jtag_tap_param.sv
// IEEE 1149.1-style TAP with parametrised IR, bypass, IDCODE/USERCODE and a
// 2*PIN_N boundary register muxed between the pads and the core.
module jtag_tap_param #(
    parameter int          IR_W         = 4,
    parameter int          PIN_N        = 4,
    parameter logic [31:0] IDCODE_VAL   = 32'h1234_5001,
    parameter logic [31:0] USERCODE_VAL = 32'hCAFE_0001
) (
    input logic             TCK,
    input logic             TRST,
    jtag_tap_param_if.slave tapBus
);

    localparam int BSR_W = 2 * PIN_N;

    localparam logic [IR_W-1:0] OP_SAMPLE   = IR_W'(4'h1);
    localparam logic [IR_W-1:0] OP_EXTEST   = IR_W'(4'h2);
    localparam logic [IR_W-1:0] OP_INTEST   = IR_W'(4'h3);
    localparam logic [IR_W-1:0] OP_CLAMP    = IR_W'(4'h5);
    localparam logic [IR_W-1:0] OP_IDCODE   = IR_W'(4'h7);
    localparam logic [IR_W-1:0] OP_USERCODE = IR_W'(4'h8);
    localparam logic [IR_W-1:0] OP_HIGHZ    = IR_W'(4'h9);
    localparam logic [IR_W-1:0] IR_CAPTURE  = IR_W'(2'b01);

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tapState_e;

    tapState_e        state_q, state_d;
    logic [IR_W-1:0]  irShift_q, irShift_d;
    logic [IR_W-1:0]  irOut_q, irOut_d;
    logic [BSR_W-1:0] bsrShift_q, bsrShift_d;
    logic [BSR_W-1:0] bsrUpd_q, bsrUpd_d;
    logic [31:0]      idShift_q, idShift_d;
    logic             bypass_q, bypass_d;
    logic             tdo_q, tdo_d;
    logic             tdoEn_q, tdoEn_d;

    logic captureDr, shiftDr, updateDr, captureIr, shiftIr, updateIr, inReset;
    logic selBsr, selId, isUser, drLsb;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q    <= TLR;
            irShift_q  <= '0;
            bsrShift_q <= '0;
            idShift_q  <= '0;
            bypass_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            irShift_q  <= irShift_d;
            bsrShift_q <= bsrShift_d;
            idShift_q  <= idShift_d;
            bypass_q   <= bypass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:    state_d = tapBus.TMS ? TLR    : RTI;
            RTI:    state_d = tapBus.TMS ? SEL_DR : RTI;
            SEL_DR: state_d = tapBus.TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_d = tapBus.TMS ? EX1_DR : SH_DR;
            SH_DR:  state_d = tapBus.TMS ? EX1_DR : SH_DR;
            EX1_DR: state_d = tapBus.TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_d = tapBus.TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_d = tapBus.TMS ? UPD_DR : SH_DR;
            UPD_DR: state_d = tapBus.TMS ? SEL_DR : RTI;
            SEL_IR: state_d = tapBus.TMS ? TLR    : CAP_IR;
            CAP_IR: state_d = tapBus.TMS ? EX1_IR : SH_IR;
            SH_IR:  state_d = tapBus.TMS ? EX1_IR : SH_IR;
            EX1_IR: state_d = tapBus.TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_d = tapBus.TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_d = tapBus.TMS ? UPD_IR : SH_IR;
            UPD_IR: state_d = tapBus.TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_comb begin
        tapBus.tap_state = state_q;
        captureDr        = (state_q == CAP_DR);
        shiftDr          = (state_q == SH_DR);
        updateDr         = (state_q == UPD_DR);
        captureIr        = (state_q == CAP_IR);
        shiftIr          = (state_q == SH_IR);
        updateIr         = (state_q == UPD_IR);
        inReset          = (state_q == TLR);
    end

    // Unknown opcodes fall through every compare and land on the bypass register.
    always_comb begin
        selBsr = (irOut_q == OP_SAMPLE) || (irOut_q == OP_EXTEST) || (irOut_q == OP_INTEST);
        selId  = (irOut_q == OP_IDCODE) || (irOut_q == OP_USERCODE);
        isUser = (irOut_q == OP_USERCODE);
        drLsb  = selBsr ? bsrShift_q[0] : (selId ? idShift_q[0] : bypass_q);
    end

    always_comb begin
        irShift_d = irShift_q;
        if (captureIr)
            irShift_d = IR_CAPTURE;
        else if (shiftIr)
            irShift_d = {tapBus.TDI, irShift_q[IR_W-1:1]};

        bsrShift_d = bsrShift_q;
        if (captureDr && selBsr)
            bsrShift_d = {tapBus.core_out, tapBus.pin_in};
        else if (shiftDr && selBsr)
            bsrShift_d = {tapBus.TDI, bsrShift_q[BSR_W-1:1]};

        idShift_d = idShift_q;
        if (captureDr && selId)
            idShift_d = isUser ? USERCODE_VAL : IDCODE_VAL;
        else if (shiftDr && selId)
            idShift_d = {tapBus.TDI, idShift_q[31:1]};

        bypass_d = bypass_q;
        if (captureDr && !selBsr && !selId)
            bypass_d = 1'b0;
        else if (shiftDr && !selBsr && !selId)
            bypass_d = tapBus.TDI;
    end

    // Falling-edge stage: the updated IR, BSR update latches and TDO driver.
    always_comb begin
        irOut_d  = irOut_q;
        bsrUpd_d = bsrUpd_q;
        if (inReset) begin
            irOut_d  = OP_IDCODE;
            bsrUpd_d = '0;
        end else if (updateIr) begin
            irOut_d = irShift_q;
        end else if (updateDr && selBsr) begin
            bsrUpd_d = bsrShift_q;
        end
        tdoEn_d = shiftDr || shiftIr;
        tdo_d   = shiftIr ? irShift_q[0] : (shiftDr ? drLsb : 1'b0);
    end

    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            irOut_q  <= OP_IDCODE;
            bsrUpd_q <= '0;
            tdo_q    <= 1'b0;
            tdoEn_q  <= 1'b0;
        end else begin
            irOut_q  <= irOut_d;
            bsrUpd_q <= bsrUpd_d;
            tdo_q    <= tdo_d;
            tdoEn_q  <= tdoEn_d;
        end
    end

    always_comb begin
        tapBus.core_in = tapBus.pin_in;
        tapBus.pin_out = tapBus.core_out;
        tapBus.pin_oe  = tapBus.core_oe;
        case (irOut_q)
            OP_EXTEST, OP_CLAMP: begin
                tapBus.pin_out = bsrUpd_q[BSR_W-1:PIN_N];
                tapBus.pin_oe  = '1;
            end
            OP_INTEST: begin
                tapBus.core_in = bsrUpd_q[PIN_N-1:0];
                tapBus.pin_out = bsrUpd_q[BSR_W-1:PIN_N];
                tapBus.pin_oe  = '1;
            end
            OP_HIGHZ: tapBus.pin_oe = '0;
            default: ;
        endcase
    end

    assign tapBus.ir_out = irOut_q;
    assign tapBus.TDO    = tdo_q;
    assign tapBus.TDO_EN = tdoEn_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Self-checking bench for jtag_tap_param: a TDO scoreboard fed by the scan
// tasks, a pad-mux vector table, and hand-written pause/reset sequences.
module tb_jtag_tap_param;

    localparam int          IR_W     = 4;
    localparam int          PIN_N    = 4;
    localparam logic [31:0] IDCODE   = 32'h1234_5001;
    localparam logic [31:0] USERCODE = 32'hCAFE_0001;

    logic tck;
    logic trst;

    jtag_tap_param_if #(.IR_W(IR_W), .PIN_N(PIN_N)) bus ();

    jtag_tap_param #(
        .IR_W(IR_W), .PIN_N(PIN_N), .IDCODE_VAL(IDCODE), .USERCODE_VAL(USERCODE)
    ) dut (
        .TCK(tck), .TRST(trst), .tapBus(bus)
    );

    int   compared   = 0;
    int   mismatched = 0;
    bit   monitorOn  = 0;
    logic expQ[$];

    typedef struct {
        logic [3:0] op;
        logic [3:0] coreIn;
        logic [3:0] pinOut;
        logic [3:0] pinOe;
        bit         chkPinOut;
    } padVec_t;

    padVec_t vecs[10];

    initial tck = 1'b0;
    always #10 tck = ~tck;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One TCK cycle: drive TMS/TDI, then return just after the falling edge.
    task automatic applyStimulus(input logic tms, input logic tdi);
        bus.TMS = tms;
        bus.TDI = tdi;
        @(posedge tck);
        @(negedge tck);
        #1;
    endtask

    // Register of length len captured with cap, shifted with tdi: what TDO shows.
    function automatic logic [63:0] expStream(input logic [63:0] cap, input int len,
                                              input logic [63:0] tdi, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++)
            r[i] = (i < len) ? cap[i] : tdi[i-len];
        return r;
    endfunction

    always begin
        logic expBit;
        @(negedge tck);
        #2;
        if (monitorOn && bus.TDO_EN) begin
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL tdo_stream: got %0b with nothing expected", bus.TDO);
            end else begin
                expBit = expQ.pop_front();
                checkOutput("tdo_stream", 64'(bus.TDO), 64'(expBit));
            end
        end
    end

    task automatic pushExpected(input int n, input logic [63:0] exp);
        for (int i = 0; i < n; i++)
            expQ.push_back(exp[i]);
    endtask

    task automatic scanDr(input int n, input logic [63:0] tdi, input logic [63:0] exp);
        pushExpected(n, exp);
        monitorOn = 1;
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        for (int i = 0; i < n; i++)
            applyStimulus(i == n - 1, tdi[i]);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        monitorOn = 0;
    endtask

    task automatic loadIr(input logic [3:0] code);
        pushExpected(IR_W, expStream(64'(IR_W'(2'b01)), IR_W, 64'(code), IR_W));
        monitorOn = 1;
        applyStimulus(1, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        for (int i = 0; i < IR_W; i++)
            applyStimulus(i == IR_W - 1, code[i]);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        monitorOn = 0;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] extestBits;

        vecs[0] = '{4'h1, 4'h5, 4'h3, 4'h6, 1'b1};
        vecs[1] = '{4'h2, 4'h5, 4'hA, 4'hF, 1'b1};
        vecs[2] = '{4'h3, 4'h0, 4'hA, 4'hF, 1'b1};
        vecs[3] = '{4'h5, 4'h5, 4'hA, 4'hF, 1'b1};
        vecs[4] = '{4'h9, 4'h5, 4'h3, 4'h0, 1'b0};
        vecs[5] = '{4'h7, 4'h5, 4'h3, 4'h6, 1'b1};
        vecs[6] = '{4'h8, 4'h5, 4'h3, 4'h6, 1'b1};
        vecs[7] = '{4'hF, 4'h5, 4'h3, 4'h6, 1'b1};
        vecs[8] = '{4'h4, 4'h5, 4'h3, 4'h6, 1'b1};
        vecs[9] = '{4'h0, 4'h5, 4'h3, 4'h6, 1'b1};

        trst         = 1'b0;
        bus.TMS      = 1'b1;
        bus.TDI      = 1'b0;
        bus.pin_in   = 4'h5;
        bus.core_out = 4'h3;
        bus.core_oe  = 4'h6;
        #25;
        checkOutput("rst_tap_state", 64'(bus.tap_state), 64'hF);
        checkOutput("rst_ir_out",    64'(bus.ir_out),    64'h7);
        checkOutput("rst_tdo_en",    64'(bus.TDO_EN),    64'h0);
        checkOutput("rst_tdo",       64'(bus.TDO),       64'h0);
        checkOutput("rst_pin_oe",    64'(bus.pin_oe),    64'h6);
        checkOutput("rst_pin_out",   64'(bus.pin_out),   64'h3);
        checkOutput("rst_core_in",   64'(bus.core_in),   64'h5);

        trst = 1'b1;
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        checkOutput("rti_state", 64'(bus.tap_state), 64'hC);

        scanDr(32, 64'h0, expStream(64'(IDCODE), 32, 64'h0, 32));

        loadIr(4'h2);
        checkOutput("extest_ir_out", 64'(bus.ir_out), 64'h2);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        checkOutput("shdr_state",  64'(bus.tap_state), 64'h2);
        checkOutput("shdr_tdo_en", 64'(bus.TDO_EN),    64'h1);
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 0);
        checkOutput("tmsrst_state",  64'(bus.tap_state), 64'hF);
        checkOutput("tmsrst_ir_out", 64'(bus.ir_out),    64'h7);
        checkOutput("tmsrst_tdo_en", 64'(bus.TDO_EN),    64'h0);
        checkOutput("tmsrst_pin_oe", 64'(bus.pin_oe),    64'h6);
        applyStimulus(0, 0);

        loadIr(4'h8);
        checkOutput("usercode_ir_out", 64'(bus.ir_out), 64'h8);
        scanDr(32, 64'h0, expStream(64'(USERCODE), 32, 64'h0, 32));

        loadIr(4'hF);
        scanDr(9, 64'h081, expStream(64'h0, 1, 64'h081, 9));

        // EXTEST scan split by a pause; captured {core_out, pin_in} = 8'h35.
        loadIr(4'h2);
        extestBits = 8'b1010_0000;
        pushExpected(8, 64'h35);
        monitorOn = 1;
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(i == 3, extestBits[i]);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 0);
        checkOutput("pause_state",   64'(bus.tap_state), 64'h3);
        checkOutput("pause_tdo_en",  64'(bus.TDO_EN),    64'h0);
        checkOutput("pause_pin_out", 64'(bus.pin_out),   64'h0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        for (int i = 4; i < 8; i++)
            applyStimulus(i == 7, extestBits[i]);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        monitorOn = 0;
        checkOutput("extest_pin_out", 64'(bus.pin_out), 64'hA);
        checkOutput("extest_pin_oe",  64'(bus.pin_oe),  64'hF);
        checkOutput("extest_core_in", 64'(bus.core_in), 64'h5);

        foreach (vecs[k]) begin
            loadIr(vecs[k].op);
            checkOutput($sformatf("op%0h_ir_out", vecs[k].op), 64'(bus.ir_out), 64'(vecs[k].op));
            checkOutput($sformatf("op%0h_core_in", vecs[k].op), 64'(bus.core_in), 64'(vecs[k].coreIn));
            checkOutput($sformatf("op%0h_pin_oe", vecs[k].op), 64'(bus.pin_oe), 64'(vecs[k].pinOe));
            if (vecs[k].chkPinOut)
                checkOutput($sformatf("op%0h_pin_out", vecs[k].op), 64'(bus.pin_out), 64'(vecs[k].pinOut));
        end

        loadIr(4'h5);
        scanDr(4, 64'hB, expStream(64'h0, 1, 64'hB, 4));
        checkOutput("clamp_pin_out_kept", 64'(bus.pin_out), 64'hA);
        checkOutput("clamp_pin_oe",       64'(bus.pin_oe),  64'hF);

        loadIr(4'h2);
        checkOutput("extest2_pin_out", 64'(bus.pin_out), 64'hA);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        applyStimulus(0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 1);
        trst = 1'b0;
        #1;
        checkOutput("trst_pin_oe",    64'(bus.pin_oe),    64'h6);
        checkOutput("trst_pin_out",   64'(bus.pin_out),   64'h3);
        checkOutput("trst_core_in",   64'(bus.core_in),   64'h5);
        checkOutput("trst_ir_out",    64'(bus.ir_out),    64'h7);
        checkOutput("trst_state",     64'(bus.tap_state), 64'hF);
        checkOutput("trst_tdo_en",    64'(bus.TDO_EN),    64'h0);
        #5;
        trst = 1'b1;
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        loadIr(4'h2);
        checkOutput("post_trst_pin_out", 64'(bus.pin_out), 64'h0);

        checkOutput("queue_drained", 64'(expQ.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jtag_tap_param.md
# jtag_tap_param

Parametrised IEEE 1149.1-style TAP controller with instruction register, bypass, 32-bit IDCODE/USERCODE and a boundary-scan register wrapping `PIN_N` input pins and `PIN_N` output pins. It succeeds the fixed 4-bit-IR, fixed-length `ics` block. New capabilities are a configurable IR width and pin count, identification registers, and CLAMP/HIGHZ/INTEST pad-control modes. It sits between the chip pads and the core logic. Only the TAP pins reach the test header.

## Interface
Parameters:
- `IR_W`, 4: instruction register width, ≥4. Opcodes are the 4-bit values below, zero-extended. The all-ones code is BYPASS.
- `PIN_N`, 4: number of input pins and number of output pins. The boundary register (BSR) length is 2·PIN_N.
- `IDCODE_VAL`, 32'h1234_5001: IDCODE register contents. Bit 0 must be 1.
- `USERCODE_VAL`, 32'hCAFE_0001: USERCODE register contents.

Ports:
- `TCK` in 1: the single clock. All state changes on `TCK` edges.
- `TRST` in 1: asynchronous, active-low reset.
- `TMS` in 1: test mode select, sampled on TCK rise.
- `TDI` in 1: test data in, sampled on TCK rise.
- `TDO` out 1: test data out, changes on TCK fall.
- `TDO_EN` out 1: TDO output enable.
- `tap_state` out 4: current TAP state encoding, for debug.
- `ir_out` out IR_W: active (updated) instruction.
- `pin_in` in PIN_N: values from the input pads.
- `core_in` out PIN_N: values to the core for the input pins.
- `core_out` in PIN_N: values from the core for the output pins.
- `pin_out` out PIN_N: values to the output pads.
- `pin_oe` out PIN_N: output pad enables.
- `core_oe` in PIN_N: output enables from the core.

## Operation
TAP FSM:
- Standard 16 states, encoded F TLR, C RTI, 7 SelDR, 6 CapDR, 2 ShDR, 1 Ex1DR, 3 PauDR, 0 Ex2DR, 5 UpdDR, 4 SelIR, E CapIR, A ShIR, 9 Ex1IR, B PauIR, 8 Ex2IR, D UpdIR.
- Standard TMS transitions apply.
- Five consecutive TMS=1 rises reach TLR from any state.

Instructions (4-bit code, zero-extended to IR_W):
- BYPASS F
- SAMPLE 1
- EXTEST 2
- INTEST 3
- CLAMP 5
- IDCODE 7
- USERCODE 8
- HIGHZ 9
- Any other code behaves as BYPASS.

Data register select:
- BSR for SAMPLE, EXTEST and INTEST.
- 32-bit ID register for IDCODE and USERCODE.
- 1-bit bypass register for all other instructions.

IR path:
- CapIR loads the IR shift register with {0…0,2'b01}.
- ShIR shifts TDI into the MSB; TDO shows the LSB.
- UpdIR copies the shift register to `ir_out`.

DR path:
- CapDR loads the selected register:
  - BSR ← {core_out, pin_in}, with input cells at [PIN_N-1:0].
  - ID ← IDCODE_VAL or USERCODE_VAL.
  - Bypass ← 0.
- ShDR shifts the selected register one bit, TDI into the MSB, LSB to TDO.
- UpdDR copies the BSR shift stage into the BSR update stage. UpdDR has no effect for the ID and bypass registers.
- Pause and Exit states hold register contents.

Pad muxing (upd = BSR update stage):
- SAMPLE, BYPASS, IDCODE, USERCODE and unknown codes: `core_in`=pin_in, `pin_out`=core_out, `pin_oe`=core_oe.
- EXTEST: `pin_out`=upd[2N-1:N], `pin_oe`=all 1, `core_in`=pin_in.
- INTEST: `core_in`=upd[N-1:0], `pin_out`=upd[2N-1:N], `pin_oe`=all 1.
- CLAMP: `pin_out`=upd[2N-1:N], `pin_oe`=all 1, `core_in`=pin_in. The data register is bypass.
- HIGHZ: `pin_oe`=all 0, `core_in`=pin_in. The data register is bypass.

## Timing
Edges:
- Rising TCK updates the FSM, the capture/shift stages, and the IR/DR shift registers.
- Falling TCK updates `ir_out`, the BSR update stage, `TDO` and `TDO_EN`.

Reset values, on TRST low or on entry to TLR:
- FSM = F.
- `ir_out` = IDCODE (7).
- BSR update stage = 0.
- `TDO`=0, `TDO_EN`=0.
- Pad mux in SAMPLE-equivalent passthrough.

Reset mid-shift:
- Shifted bits are discarded.
- No update occurs.

TDO and TDO_EN:
- `TDO_EN`=1 only on the half-cycles following a rise that left the FSM in ShDR or ShIR.
- Otherwise `TDO_EN`=0 and `TDO`=0.
- Shift latency TDI→TDO is register length L rises. Bypass gives exactly 1 rise of delay.

IR update timing:
- The new IR takes effect at the falling edge during UpdIR.
- The pad mux changes combinationally from `ir_out`.

PauDR/PauIR of any length, then resume via Ex2→Sh, preserves previously shifted bits.

## Test plan
- **Reset and TMS reset:** drive TRST low, then run 5 TMS=1 cycles from ShDR → tap_state=F, ir_out=7, TDO_EN=0, pin_oe=core_oe.
- **IDCODE read:** after reset, shift 32 DR bits with TDI=0 → TDO stream LSB-first equals 32'h1234_5001.
- **IR capture and load:**
  - CapIR followed by shifting 4'b1000 (USERCODE) → TDO shows the 2'b01 capture pattern in its first two bits.
  - After UpdIR, ir_out=8.
  - A DR scan then returns 32'hCAFE_0001.
- **BYPASS:** IR=F, shift 8'b10000001 through DR → TDO reproduces it delayed by one TCK.
- **EXTEST with pause:**
  - PIN_N=4, IR=2.
  - Shift 8'b1010_0000 split by 4 PauDR cycles, then UpdDR.
  - Expect pin_out=4'b1010 and pin_oe=4'hF.
  - A capture with pin_in=4'h5 and core_out=4'h3 shifts out 8'h35.
- **HIGHZ/CLAMP:**
  - IR=9 → pin_oe=0.
  - IR=5 after the EXTEST update → pin_out=4'b1010 and DR length 1.
  - Assert TRST mid-shift → passthrough restored immediately.
